// File: rtl/modn_pkg.sv
// modn_pkg: shared defaults and width helper for the mod-N counter chain
package modn_pkg;
    localparam int DEF_MODULUS = 6;
    localparam int DEF_STAGES  = 2;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/modn_stage.sv
// modn_stage: one modulo-MODULUS up/down digit with clamping parallel load
module modn_stage
    import modn_pkg::*;
#(
    parameter int MODULUS = DEF_MODULUS,
    parameter int W       = clog2_min1(MODULUS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         up_dn,
    input  logic         load,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] q,
    output logic         at_term,
    output logic         ld_bad
);
    localparam logic [W-1:0] MAX = W'(MODULUS - 1);

    logic [W-1:0] r_q;
    logic [W-1:0] w_nxt;

    // Widen by one bit so a power-of-2 modulus never aliases to zero
    assign ld_bad  = {1'b0, ld_val} >= (W+1)'(MODULUS);
    assign at_term = up_dn ? (r_q == MAX) : (r_q == '0);
    assign w_nxt   = up_dn ? (at_term ? '0 : r_q + 1'b1) : (at_term ? MAX : r_q - 1'b1);
    assign q       = r_q;

    always_ff @(posedge clk) begin
        if (rst)
            r_q <= '0;
        else if (load)
            r_q <= ld_bad ? MAX : ld_val;
        else if (step)
            r_q <= w_nxt;
    end
endmodule

// File: rtl/modn_counter_chain.sv
// modn_counter_chain: cascade of mod-N up/down digits with terminal count, wrap and load-error pulses
module modn_counter_chain
    import modn_pkg::*;
#(
    parameter int MODULUS    = DEF_MODULUS,
    parameter int NUM_STAGES = DEF_STAGES,
    parameter int W          = clog2_min1(MODULUS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [NUM_STAGES*W-1:0] load_val,
    output logic [NUM_STAGES*W-1:0] count,
    output logic                    tc,
    output logic                    wrapped,
    output logic                    load_err
);
    logic [NUM_STAGES:0]   w_chain;
    logic [NUM_STAGES-1:0] w_at_term;
    logic [NUM_STAGES-1:0] w_bad;
    logic                  r_wrapped;
    logic                  r_load_err;

    // w_chain[i] is high when every digit below i sits at its terminal value
    assign w_chain[0] = 1'b1;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        assign w_chain[i+1] = w_chain[i] & w_at_term[i];
        modn_stage #(
            .MODULUS(MODULUS),
            .W      (W)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .step   (en & ~load & w_chain[i]),
            .up_dn  (up_dn),
            .load   (load),
            .ld_val (load_val[i*W +: W]),
            .q      (count[i*W +: W]),
            .at_term(w_at_term[i]),
            .ld_bad (w_bad[i])
        );
    end

    assign tc       = en & w_chain[NUM_STAGES];
    assign wrapped  = r_wrapped;
    assign load_err = r_load_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrapped  <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrapped  <= tc & ~load;
            r_load_err <= load & (|w_bad);
        end
    end
endmodule
